conv_encoder_batch_normalization_apply: RTL and testbench

CONV_ENCODER_BATCH_NORMALIZATION_APPLY -- requirements
Module: conv_encoder_batch_normalization_apply

---
 rtl/conv_encoder_batch_normalization_apply.sv | 113 +++++++++++
 tb/tb_conv_encoder_batch_normalization_apply.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_batch_normalization_apply.sv
// conv_encoder_batch_normalization_apply: per-filter y = sat((x*p + q) >>> FRAC) over N_PIX samples,
// 3-stage stallable pipeline; optional ReLU after saturation when BN_RELU_EN is defined.
module conv_encoder_batch_normalization_apply #(
   parameter int IN_W  = 18,
   parameter int OUT_W = 18,
   parameter int FRAC  = 16,
   parameter int N_PIX = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    filter_start,
   input  logic [3:0]              filter_id,
   output logic                    param_start,
   output logic [3:0]              param_sel,
   input  logic signed [17:0]      param_p,
   input  logic signed [35:0]      param_q,
   input  logic                    param_ready,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    busy,
   output logic                    done
);
   typedef enum logic [2:0] {IDLE, FETCH, WAITP, RUN, DRAIN} state_t;
   localparam logic [15:0] LAST = 16'(N_PIX - 1);
   localparam logic signed [36:0] MAXV = 37'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [36:0] MINV = -MAXV - 37'sd1;

   state_t                   r_state;
   logic [15:0]              r_in_cnt, r_out_cnt;
   logic [3:0]               r_sel;
   logic signed [17:0]       r_p;
   logic signed [35:0]       r_q;
   logic                     r_v1, r_v2, r_v3, r_done;
   logic signed [IN_W-1:0]   r_x;
   logic signed [IN_W+17:0]  r_prod;
   logic signed [OUT_W-1:0]  r_y;
   logic                     w_adv, w_in_hs, w_out_hs;
   logic signed [36:0]       w_sum, w_sh;
   logic signed [OUT_W-1:0]  w_sat, w_y;

   // the whole pipeline moves only when the output slot is free or being drained
   assign w_adv    = !r_v3 || out_ready;
   assign in_ready = (r_state == RUN) && w_adv;
   assign w_in_hs  = in_valid && in_ready;
   assign w_out_hs = r_v3 && out_ready;
   assign w_sum    = 37'(r_prod) + 37'(r_q);
   assign w_sh     = w_sum >>> FRAC;
   assign w_sat    = (w_sh > MAXV) ? MAXV[OUT_W-1:0] : (w_sh < MINV) ? MINV[OUT_W-1:0] : w_sh[OUT_W-1:0];
`ifdef BN_RELU_EN
   assign w_y = w_sat[OUT_W-1] ? '0 : w_sat;
`else
   assign w_y = w_sat;
`endif

   assign param_start = (r_state == FETCH);
   assign param_sel   = r_sel;
   assign out_valid   = r_v3;
   assign out_data    = r_y;
   assign busy        = (r_state != IDLE);
   assign done        = r_done;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
         r_sel     <= '0;
         r_p       <= '0;
         r_q       <= '0;
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_v3      <= 1'b0;
         r_done    <= 1'b0;
         r_x       <= '0;
         r_prod    <= '0;
         r_y       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE:  if (filter_start) begin
               r_sel   <= filter_id;
               r_state <= FETCH;
            end
            FETCH: r_state <= WAITP;
            WAITP: if (param_ready) begin
               r_p     <= param_p;
               r_q     <= param_q;
               r_state <= RUN;
            end
            RUN:   if (w_in_hs && r_in_cnt == LAST) r_state <= DRAIN;
            DRAIN: if (w_out_hs && r_out_cnt == LAST) begin
               r_state <= IDLE;
               r_done  <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
         r_in_cnt  <= (r_state == FETCH) ? '0 : w_in_hs ? r_in_cnt + 16'd1 : r_in_cnt;
         r_out_cnt <= (r_state == FETCH) ? '0 : w_out_hs ? r_out_cnt + 16'd1 : r_out_cnt;
         if (w_adv) begin
            r_v1   <= w_in_hs;
            r_x    <= in_data;
            r_v2   <= r_v1;
            r_prod <= r_x * r_p;
            r_v3   <= r_v2;
            r_y    <= w_y;
         end
      end
   end
endmodule

// File: tb/tb_conv_encoder_batch_normalization_apply.sv
// tb_conv_encoder_batch_normalization_apply: randomized passes with a scoreboard queue fed on input
// handshakes and drained by an output monitor; reference is plain integer arithmetic.
module tb_conv_encoder_batch_normalization_apply;
   localparam int NP = 4;
   logic clk = 0, rst = 0, filter_start = 0, param_ready = 0, in_valid = 0, out_ready = 1;
   logic [3:0] filter_id = 0;
   logic signed [17:0] param_p = 0, in_data = 0;
   logic signed [35:0] param_q = 0;
   logic param_start, in_ready, out_valid, busy, done;
   logic [3:0] param_sel;
   logic signed [17:0] out_data;

   conv_encoder_batch_normalization_apply #(.IN_W(18), .OUT_W(18), .FRAC(16), .N_PIX(NP)) dut (
      .clk(clk), .rst(rst), .filter_start(filter_start), .filter_id(filter_id),
      .param_start(param_start), .param_sel(param_sel), .param_p(param_p), .param_q(param_q),
      .param_ready(param_ready), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done));

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0, n_out = 0, n_done = 0, n_ps = 0, cyc = 0, rmode = 1;
   bit lat_on = 0;
   logic signed [17:0] mp;
   logic signed [35:0] mq;
   logic signed [17:0] xs [NP];
   logic signed [17:0] exp_q [$];
   int ts_q [$];

   task automatic check(input string nm, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic signed [17:0] ref_y(input longint x, input longint p, input longint q);
      longint s;
      s = (x * p + q) >>> 16;
      if (s > 131071) s = 131071;
      if (s < -131072) s = -131072;
`ifdef BN_RELU_EN
      if (s < 0) s = 0;
`endif
      return s[17:0];
   endfunction

   always @(posedge clk) cyc++;

   initial forever begin
      @(posedge clk);
      #2 out_ready = (rmode == 0) ? ($urandom_range(0, 3) != 0) : (rmode == 1);
   end

   always @(negedge clk) begin
      if (in_valid && in_ready) begin
         exp_q.push_back(ref_y(in_data, mp, mq));
         ts_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) check("unexpected_output", 1, 0);
         else begin
            check("out_data", out_data, exp_q.pop_front());
            if (lat_on) check("latency", cyc - ts_q.pop_front(), 3);
            else void'(ts_q.pop_front());
         end
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (done) n_done++;
      if (param_start) n_ps++;
   end

   task automatic feed(input logic signed [17:0] x);
      bit got = 0;
      if (rmode == 0) begin
         in_valid = 0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1;
      in_data = x;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      if (!got) check("in_handshake_timeout", 0, 1);
   endtask

   task automatic do_pass(input logic [3:0] fid, input int wcyc, input int stall_after);
      int n0, d0, p0;
      bit seen = 0, got = 0;
      n0 = n_out; d0 = n_done; p0 = n_ps;
      @(posedge clk); #1 filter_start = 1; filter_id = fid;
      @(posedge clk); #1 filter_start = 0; filter_id = ~fid;
      @(negedge clk);
      check("param_start", param_start, 1);
      check("param_sel", param_sel, fid);
      repeat (wcyc + 1) begin
         @(posedge clk); #1;
         @(negedge clk);
         seen |= in_ready || !busy || param_start;
      end
      check("waitp_idle", seen, 0);
      @(posedge clk); #1 param_p = mp; param_q = mq; param_ready = 1;
      @(posedge clk); #1 param_ready = 0; param_p = 18'($urandom); param_q = 36'({$urandom, $urandom});
      filter_start = 1; filter_id = fid ^ 4'h5;
      @(posedge clk); #1 filter_start = 0;
      for (int i = 0; i < NP; i++) begin
         feed(xs[i]);
         if (i == stall_after) begin
            rmode = 2;
            repeat (5) begin @(posedge clk); #1; end
            rmode = 1;
         end
      end
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            check("busy_at_done", busy, 0);
         end
      end
      if (!got) check("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      check("done_count", n_done - d0, 1);
      check("out_count", n_out - n0, NP);
      check("param_start_count", n_ps - p0, 1);
      check("param_sel_held", param_sel, fid);
      check("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_param_sel", param_sel, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1 rst = 1;

      mp = 83; mq = 689350;
      check("model_scenario_a", ref_y(1000, mp, mq), 11);
      xs[0] = 1000; xs[1] = 0; xs[2] = -1000; xs[3] = 131071;
      lat_on = 1; rmode = 1;
      do_pass(4'h2, 0, -1);
      lat_on = 0;

      mp = 37; mq = -940091;
      xs[0] = 100; xs[1] = 18'($urandom); xs[2] = -100; xs[3] = 18'($urandom);
      do_pass(4'h9, 10, -1);

      mp = 131071; mq = 0;
      xs[0] = 131071; xs[1] = -131072; xs[2] = 1; xs[3] = -1;
      do_pass(4'hc, 0, 1);

      for (int r = 0; r < 6; r++) begin
         mp = 18'($urandom);
         mq = 36'({$urandom, $urandom});
         for (int i = 0; i < NP; i++)
            xs[i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 18'sd131071 : -18'sd131072) : 18'($urandom);
         rmode = 0;
         do_pass(4'($urandom), $urandom_range(0, 3), -1);
         rmode = 1;
      end

      begin
         int d0, p0;
         bit bad = 0;
         rmode = 2; mp = 18'($urandom); mq = 36'({$urandom, $urandom});
         d0 = n_done;
         @(posedge clk); #1 filter_start = 1; filter_id = 4'h7;
         @(posedge clk); #1 filter_start = 0; param_p = mp; param_q = mq; param_ready = 1;
         @(posedge clk); #1;
         @(posedge clk); #1 param_ready = 0;
         feed(18'sd500);
         feed(-18'sd500);
         rst = 0; filter_start = 1; filter_id = 4'h3;
         repeat (2) @(posedge clk);
         @(negedge clk);
         check("midrst_out_valid", out_valid, 0);
         check("midrst_out_data", out_data, 0);
         check("midrst_busy", busy, 0);
         check("midrst_param_sel", param_sel, 0);
         check("midrst_in_ready", in_ready, 0);
         @(posedge clk); #1 filter_start = 0; rst = 1; rmode = 1;
         exp_q.delete(); ts_q.delete();
         p0 = n_ps;
         repeat (6) begin
            @(negedge clk);
            bad |= busy || out_valid || done;
         end
         check("post_rst_quiet", bad, 0);
         check("post_rst_done_count", n_done - d0, 0);
         check("post_rst_param_start", n_ps - p0, 0);
      end

      mp = 1000; mq = -36'sd5000000;
      for (int i = 0; i < NP; i++) xs[i] = 18'($urandom);
      do_pass(4'h1, 2, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
